// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
// Optional macro MEM_LOAD_FWD_EN: a load completes in the same cycle as its data_ok.
module mem_stage #(
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_mem_valid,
    output logic                 mem_allowin,
    input  logic                 in_gr_we,
    input  logic                 in_res_from_mem,
    input  logic [2:0]           in_mem_type,
    input  logic [1:0]           in_addr_low2,
    input  logic [RF_ADDR_W-1:0] in_dest,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_result,
    input  logic                 in_ex,
    input  logic                 in_req_sent,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 flush,
    input  logic                 wb_allowin,
    output logic                 mem_wb_valid,
    output logic                 mem_wb_gr_we,
    output logic [RF_ADDR_W-1:0] mem_wb_dest,
    output logic [31:0]          mem_wb_pc,
    output logic [31:0]          mem_wb_result,
    output logic                 mem_wb_ex,
    output logic                 mem_ex,
    output logic                 mem_fwd_valid,
    output logic [RF_ADDR_W-1:0] mem_fwd_dest,
    output logic [31:0]          mem_fwd_data,
    output logic                 mem_fwd_block
);
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    logic [1:0]           state_reg, state_next;
    logic [1:0]           discard_cnt_reg, discard_cnt_next;
    logic                 gr_we_reg, res_from_mem_reg, ex_flag_reg;
    logic [2:0]           mem_type_reg;
    logic [1:0]           addr_low2_reg;
    logic [RF_ADDR_W-1:0] dest_reg;
    logic [31:0]          pc_reg, result_reg, rdata_reg;

    logic        mem_valid, mem_ready_go, capture, transfer, need_data;
    logic        stale_ok, attributed, flush_wait_lost, rdata_load;
    logic [31:0] load_src, load_data;
    logic [7:0]  lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign mem_valid  = (state_reg != S_EMPTY);
    assign need_data  = in_req_sent & ~in_ex;
    // A response is charged to a flushed instruction first, while any remain outstanding.
    assign stale_ok   = data_sram_data_ok & (discard_cnt_reg != 2'd0);
    assign attributed = data_sram_data_ok & (discard_cnt_reg == 2'd0) & (state_reg == S_WAIT);

`ifdef MEM_LOAD_FWD_EN
    assign mem_ready_go  = (state_reg == S_READY) | attributed;
    assign load_src      = (state_reg == S_WAIT) ? data_sram_rdata : rdata_reg;
    assign rdata_load    = attributed & ~wb_allowin;
    assign mem_fwd_block = mem_valid & res_from_mem_reg & (state_reg == S_WAIT) & ~attributed;
`else
    assign mem_ready_go  = (state_reg == S_READY);
    assign load_src      = rdata_reg;
    assign rdata_load    = attributed;
    assign mem_fwd_block = mem_valid & res_from_mem_reg & (state_reg == S_WAIT);
`endif

    assign mem_allowin  = ~reset & ~flush & (~mem_valid | (mem_ready_go & wb_allowin));
    assign capture      = ex_mem_valid & mem_allowin;
    assign mem_wb_valid = mem_valid & mem_ready_go & ~flush;
    assign transfer     = mem_wb_valid & wb_allowin;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
            assign lane[gi] = load_src[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = lane[addr_low2_reg];
    assign sel_half = addr_low2_reg[1] ? load_src[31:16] : load_src[15:0];

    always_comb begin
        case (mem_type_reg[1:0])
            2'b00:   load_data = {{24{sel_byte[7] & ~mem_type_reg[2]}}, sel_byte};
            2'b01:   load_data = {{16{sel_half[15] & ~mem_type_reg[2]}}, sel_half};
            default: load_data = load_src;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        if (flush)
            state_next = S_EMPTY;
        else if (capture)
            state_next = need_data ? S_WAIT : S_READY;
        else if (transfer)
            state_next = S_EMPTY;
        else if (attributed)
            state_next = S_READY;
    end

    // A flushed WAIT leaves its response in flight; a stale response in the same cycle cancels it.
    assign flush_wait_lost = flush & (state_reg == S_WAIT) & ~attributed;

    always_comb begin
        discard_cnt_next = discard_cnt_reg;
        if (stale_ok & ~flush_wait_lost)
            discard_cnt_next = discard_cnt_reg - 2'd1;
        else if (~stale_ok & flush_wait_lost)
            discard_cnt_next = discard_cnt_reg + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= S_EMPTY;
            discard_cnt_reg  <= 2'd0;
            gr_we_reg        <= 1'b0;
            res_from_mem_reg <= 1'b0;
            ex_flag_reg      <= 1'b0;
            mem_type_reg     <= 3'd0;
            addr_low2_reg    <= 2'd0;
            dest_reg         <= '0;
            pc_reg           <= 32'd0;
            result_reg       <= 32'd0;
            rdata_reg        <= 32'd0;
        end else begin
            state_reg       <= state_next;
            discard_cnt_reg <= discard_cnt_next;
            if (capture) begin
                gr_we_reg        <= in_gr_we;
                res_from_mem_reg <= in_res_from_mem;
                ex_flag_reg      <= in_ex;
                mem_type_reg     <= in_mem_type;
                addr_low2_reg    <= in_addr_low2;
                dest_reg         <= in_dest;
                pc_reg           <= in_pc;
                result_reg       <= in_result;
            end
            if (rdata_load)
                rdata_reg <= data_sram_rdata;
        end
    end

    assign mem_wb_gr_we  = gr_we_reg;
    assign mem_wb_dest   = dest_reg;
    assign mem_wb_pc     = pc_reg;
    assign mem_wb_ex     = ex_flag_reg;
    assign mem_wb_result = res_from_mem_reg ? load_data : result_reg;
    assign mem_ex        = mem_valid & ex_flag_reg;
    assign mem_fwd_valid = mem_valid & gr_we_reg & ~ex_flag_reg;
    assign mem_fwd_dest  = dest_reg;
    assign mem_fwd_data  = mem_wb_result;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes expected records, monitor checks outputs.
module tb_mem_stage;
    localparam int W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, ex_mem_valid, in_gr_we, in_res_from_mem, in_ex, in_req_sent;
    logic [2:0]    in_mem_type;
    logic [1:0]    in_addr_low2;
    logic [W-1:0]  in_dest;
    logic [31:0]   in_pc, in_result, data_sram_rdata;
    logic          data_sram_data_ok, flush, wb_allowin;
    logic          mem_allowin, mem_wb_valid, mem_wb_gr_we, mem_wb_ex, mem_ex;
    logic          mem_fwd_valid, mem_fwd_block;
    logic [W-1:0]  mem_wb_dest, mem_fwd_dest;
    logic [31:0]   mem_wb_pc, mem_wb_result, mem_fwd_data;

    mem_stage #(.RF_ADDR_W(W)) dut (
        .clk(clk), .reset(reset), .ex_mem_valid(ex_mem_valid), .mem_allowin(mem_allowin),
        .in_gr_we(in_gr_we), .in_res_from_mem(in_res_from_mem), .in_mem_type(in_mem_type),
        .in_addr_low2(in_addr_low2), .in_dest(in_dest), .in_pc(in_pc), .in_result(in_result),
        .in_ex(in_ex), .in_req_sent(in_req_sent), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .flush(flush), .wb_allowin(wb_allowin),
        .mem_wb_valid(mem_wb_valid), .mem_wb_gr_we(mem_wb_gr_we), .mem_wb_dest(mem_wb_dest),
        .mem_wb_pc(mem_wb_pc), .mem_wb_result(mem_wb_result), .mem_wb_ex(mem_wb_ex),
        .mem_ex(mem_ex), .mem_fwd_valid(mem_fwd_valid), .mem_fwd_dest(mem_fwd_dest),
        .mem_fwd_data(mem_fwd_data), .mem_fwd_block(mem_fwd_block)
    );

    typedef struct packed {
        logic         gr_we;
        logic [W-1:0] dest;
        logic [31:0]  pc;
        logic [31:0]  result;
        logic         ex;
    } rec_t;

    typedef struct packed {
        int          tag;
        logic [31:0] data;
        int          delay;
    } mreq_t;

    rec_t  exp_q[$];
    mreq_t mem_q[$];
    int    compared = 0;
    int    mismatched = 0;
    bit    monitor_on = 0;

    // Model of the instruction held by the stage, tracked at the handshake level.
    bit    pending = 0, cur_need = 0, cur_got = 0, cur_load = 0;
    rec_t  cur;
    int    cur_id = -1;
    int    next_id = 0;

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [2:0] ty,
                                             input logic [1:0] lo);
        int unsigned v;
        if (ty[1:0] == 2'b00) begin
            v = (rd >> (8 * lo)) % 256;
            if (!ty[2] && v >= 128) v = v + 32'hFFFF_FF00;
            return v;
        end else if (ty[1:0] == 2'b01) begin
            v = (rd >> (16 * lo[1])) % 65536;
            if (!ty[2] && v >= 32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return rd;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit we, input bit ld, input logic [2:0] ty,
                         input logic [1:0] lo, input logic [W-1:0] d, input logic [31:0] pc,
                         input logic [31:0] res, input bit ex, input bit rs,
                         input logic [31:0] rd, input int dly, input bit fl, input bit wa);
        bit    cap, dok, rdy;
        mreq_t m;
        @(negedge clk);
        ex_mem_valid = v; in_gr_we = we; in_res_from_mem = ld; in_mem_type = ty;
        in_addr_low2 = lo; in_dest = d; in_pc = pc; in_result = res; in_ex = ex;
        in_req_sent = rs; flush = fl; wb_allowin = wa;
        if (mem_q.size() > 0 && mem_q[0].delay == 0) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = mem_q[0].data;
        end else begin
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = $urandom;
        end
        dok = data_sram_data_ok;
        #1;
        cap = v && (mem_allowin === 1'b1);
        @(posedge clk);
        rdy = pending && (!cur_need || cur_got);
        if (dok) begin
            m = mem_q.pop_front();
            if (pending && m.tag == cur_id) cur_got = 1;
        end else if (mem_q.size() > 0) begin
            m = mem_q[0];
            if (m.delay > 0) m.delay = m.delay - 1;
            mem_q[0] = m;
        end
        if (fl) begin
            if (pending && exp_q.size() > 0) void'(exp_q.pop_back());
            pending = 0;
        end else begin
            if (pending && rdy && wa) pending = 0;
            if (cap) begin
                cur.gr_we  = we;
                cur.dest   = d;
                cur.pc     = pc;
                cur.result = ld ? ref_load(rd, ty, lo) : res;
                cur.ex     = ex;
                cur_need   = rs && !ex;
                cur_load   = ld;
                cur_got    = 0;
                cur_id     = next_id;
                next_id++;
                pending    = 1;
                exp_q.push_back(cur);
                if (cur_need) mem_q.push_back('{tag: cur_id, data: rd, delay: dly});
            end
        end
    endtask

    task automatic idle(input bit fl, input bit wa);
        drive(0, 0, 0, 3'b011, 2'd0, '0, 32'd0, 32'd0, 0, 0, 32'd0, 0, fl, wa);
    endtask

    task automatic do_reset();
        monitor_on = 0;
        @(negedge clk);
        reset = 1'b1; ex_mem_valid = 0; flush = 0; wb_allowin = 1; data_sram_data_ok = 0;
        in_req_sent = 0; in_ex = 0;
        @(negedge clk);
        #1;
        chk("reset_allowin", {31'd0, mem_allowin}, 32'd0);
        chk("reset_wb_valid", {31'd0, mem_wb_valid}, 32'd0);
        chk("reset_fwd_valid", {31'd0, mem_fwd_valid}, 32'd0);
        chk("reset_fwd_block", {31'd0, mem_fwd_block}, 32'd0);
        chk("reset_mem_ex", {31'd0, mem_ex}, 32'd0);
        chk("reset_wb_result", mem_wb_result, 32'd0);
        pending = 0; cur_got = 0; cur_need = 0;
        exp_q.delete();
        mem_q.delete();
        reset = 1'b0;
        #1;
        chk("post_reset_allowin", {31'd0, mem_allowin}, 32'd1);
        monitor_on = 1;
    endtask

    // Monitor: compares every cycle and pops the scoreboard on each write-back transfer.
    initial begin
        bit   rdy;
        rec_t e;
        forever begin
            @(negedge clk);
            #3;
            if (monitor_on) begin
                rdy = pending && (!cur_need || cur_got);
                chk("wb_valid", {31'd0, mem_wb_valid}, {31'd0, rdy && !flush});
                chk("allowin", {31'd0, mem_allowin}, {31'd0, !flush && (!pending || (rdy && wb_allowin))});
                chk("fwd_block", {31'd0, mem_fwd_block}, {31'd0, pending && cur_load && cur_need && !cur_got});
                chk("mem_ex", {31'd0, mem_ex}, {31'd0, pending && cur.ex});
                chk("fwd_valid", {31'd0, mem_fwd_valid}, {31'd0, pending && cur.gr_we && !cur.ex});
                if (pending) chk("fwd_dest", {27'd0, mem_fwd_dest}, {27'd0, cur.dest});
                if (mem_wb_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("wb_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q[0];
                        chk("wb_result", mem_wb_result, e.result);
                        chk("fwd_data", mem_fwd_data, e.result);
                        chk("wb_pc", mem_wb_pc, e.pc);
                        chk("wb_dest", {27'd0, mem_wb_dest}, {27'd0, e.dest});
                        chk("wb_gr_we", {31'd0, mem_wb_gr_we}, {31'd0, e.gr_we});
                        chk("wb_ex", {31'd0, mem_wb_ex}, {31'd0, e.ex});
                        if (wb_allowin) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ex_mem_valid = 0; in_gr_we = 0; in_res_from_mem = 0; in_mem_type = 0;
        in_addr_low2 = 0; in_dest = 0; in_pc = 0; in_result = 0; in_ex = 0; in_req_sent = 0;
        data_sram_data_ok = 0; data_sram_rdata = 0; flush = 0; wb_allowin = 1;
        do_reset();

        // ALU op, then ld.b / ld.bu at offset 3, ld.h at offset 2 with a 3-cycle response delay.
        drive(1, 1, 0, 3'b011, 2'd0, 5'd3, 32'h1000, 32'h1234, 0, 0, 32'd0, 0, 0, 1);
        idle(0, 1);
        drive(1, 1, 1, 3'b000, 2'd3, 5'd4, 32'h1004, 32'd0, 0, 1, 32'h80FF_0000, 0, 0, 1);
        repeat (3) idle(0, 1);
        drive(1, 1, 1, 3'b100, 2'd3, 5'd5, 32'h1008, 32'd0, 0, 1, 32'h80FF_0000, 0, 0, 1);
        repeat (3) idle(0, 1);
        drive(1, 1, 1, 3'b001, 2'd2, 5'd6, 32'h100C, 32'd0, 0, 1, 32'h8001_0000, 3, 0, 1);
        repeat (6) idle(0, 1);

        // Flush in WAIT, new load, then responses A (stale) and B (for the new load).
        drive(1, 1, 1, 3'b011, 2'd0, 5'd7, 32'h1010, 32'd0, 0, 1, 32'hAAAA_AAAA, 2, 0, 1);
        idle(1, 1);
        drive(1, 1, 1, 3'b011, 2'd0, 5'd8, 32'h1014, 32'd0, 0, 1, 32'hBBBB_BBBB, 0, 0, 1);
        repeat (5) idle(0, 1);
        drive(1, 1, 1, 3'b101, 2'd2, 5'd9, 32'h1018, 32'd0, 0, 1, 32'h8001_C0DE, 1, 0, 1);
        repeat (4) idle(0, 1);

        // Write-back stalled for 4 cycles after the load response.
        drive(1, 1, 1, 3'b011, 2'd0, 5'd10, 32'h101C, 32'd0, 0, 1, 32'hCAFE_F00D, 0, 0, 1);
        idle(0, 0);
        repeat (4) idle(0, 0);
        repeat (2) idle(0, 1);

        // Exception without a memory request.
        drive(1, 1, 0, 3'b011, 2'd0, 5'd11, 32'h1020, 32'h5555, 1, 0, 32'd0, 0, 0, 0);
        idle(0, 1);
        idle(0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          v, ex, canreq, ld, rs;
            logic [2:0]  ty;
            int          k;
            v      = ($urandom_range(0, 9) < 7);
            ex     = ($urandom_range(0, 15) == 0);
            canreq = (mem_q.size() <= 1);
            ld     = !ex && canreq && ($urandom_range(0, 1) == 1);
            rs     = ld || (!ex && canreq && $urandom_range(0, 3) == 0);
            k      = $urandom_range(0, 4);
            case (k)
                0: ty = 3'b000;
                1: ty = 3'b001;
                2: ty = 3'b100;
                3: ty = 3'b101;
                default: ty = 3'b011;
            endcase
            drive(v, $urandom_range(0, 1) == 1, ld, ty, 2'($urandom_range(0, 3)),
                  W'($urandom), $urandom, $urandom, ex, rs, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        end

        // Drain with a bounded cycle budget.
        for (int i = 0; i < 50 && (exp_q.size() > 0 || mem_q.size() > 0); i++) idle(0, 1);
        chk("drain_scoreboard", exp_q.size(), 32'd0);

        // Reset while a stale response is outstanding must clear the discard count.
        drive(1, 1, 1, 3'b011, 2'd0, 5'd12, 32'h2000, 32'd0, 0, 1, 32'h1111_1111, 5, 0, 1);
        idle(1, 1);
        do_reset();
        drive(1, 1, 1, 3'b000, 2'd1, 5'd13, 32'h2004, 32'd0, 0, 1, 32'h0000_9900, 0, 0, 1);
        repeat (4) idle(0, 1);
        chk("final_scoreboard", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and write-back. It takes one instruction per handshake from execute and waits for the data-SRAM `data_ok` response when execute issued a request. It extracts and extends load data, forwards results to decode, and hands a completed record to write-back. It also tracks responses still in flight from flushed instructions, so a stale `data_ok` is never attributed to a younger instruction.

## Interface
Parameters:
- `RF_ADDR_W`, default 5: destination register index width.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ex_mem_valid` in 1: execute holds a valid instruction for this stage.
- `mem_allowin` out 1: this stage accepts an instruction this cycle.
- `in_gr_we` in 1: the instruction writes the register file.
- `in_res_from_mem` in 1: the instruction is a load.
- `in_mem_type` in 3: [1:0] access size (00 byte, 01 half, 11 word); [2] 1 means zero-extend.
- `in_addr_low2` in 2: byte offset of the access.
- `in_dest` in RF_ADDR_W: destination register.
- `in_pc` in 32: instruction PC.
- `in_result` in 32: execute result.
- `in_ex` in 1: the instruction carries an exception.
- `in_req_sent` in 1: execute's data-SRAM request for this instruction was accepted (`addr_ok`).
- `data_sram_data_ok` in 1: response strobe, one per accepted request, returned in order.
- `data_sram_rdata` in 32: read data, valid with `data_ok`.
- `flush` in 1: exception or ertn flush from write-back.
- `wb_allowin` in 1: write-back can accept.
- `mem_wb_valid` out 1: record valid toward write-back.
- `mem_wb_gr_we` out 1: register write enable in the record.
- `mem_wb_dest` out RF_ADDR_W: destination register in the record.
- `mem_wb_pc` out 32: PC in the record.
- `mem_wb_result` out 32: result in the record.
- `mem_wb_ex` out 1: exception flag in the record.
- `mem_ex` out 1: `mem_valid & ex_flag`; execute uses it to suppress stores.
- `mem_fwd_valid` out 1: forwarding data valid.
- `mem_fwd_dest` out RF_ADDR_W: forwarded destination register.
- `mem_fwd_data` out 32: forwarded value.
- `mem_fwd_block` out 1: a load is waiting, so decode must stall on a matching register.

## Operation
- Capture: on `ex_mem_valid & mem_allowin`, register all `in_*` fields and set `mem_valid`. `need_data = in_req_sent & ~in_ex`.
- The FSM has three states:
  - EMPTY (`mem_valid=0`).
  - WAIT (`need_data` and no response yet).
  - READY (no response needed, or response latched into `rdata_q`).
- Transitions:
  - EMPTY→WAIT or READY on capture.
  - WAIT→READY on an attributed `data_ok`.
  - READY→EMPTY on `wb_allowin` with no new capture.
  - READY→WAIT or READY on back-to-back capture.
- Attribution: `data_ok` with `discard_cnt != 0` decrements `discard_cnt` and is ignored. Otherwise, in WAIT, it is consumed by the current instruction.
- Load extraction: select byte `rdata >> (8*addr_low2)` or half `rdata >> (16*addr_low2[1])`. Sign-extend unless `in_mem_type[2]`. Word passes through. `mem_wb_result` is the extracted data for loads, otherwise `in_result`.
- Flush: the next cycle, `mem_valid=0`, state is EMPTY, and the stage accepts no capture in the flush cycle. If the state was WAIT and no `data_ok` was attributed in the flush cycle, `discard_cnt += 1`.
- Simultaneous events:
  - Flush plus an attributed `data_ok` in WAIT: no increment.
  - A stale `data_ok` and a flush-in-WAIT in the same cycle: net unchanged.
- `discard_cnt` is 2 bits, max legal value 2.
- Forwarding:
  - `mem_fwd_valid = mem_valid & gr_we & ~ex_flag`.
  - `mem_fwd_block = mem_valid & res_from_mem & (state==WAIT)`.

## Timing
- `mem_ready_go = (state==READY)`.
- `mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin)`, and is held 0 in any flush cycle.
- `mem_wb_valid = mem_valid & mem_ready_go & ~flush`.
- Latency:
  - Non-load: one cycle (capture edge to `mem_wb_valid`).
  - Load: one cycle after `data_ok` (registered) when MEM_LOAD_FWD_EN is undefined.
- Reset values: `mem_valid=0`, `discard_cnt=0`, state EMPTY. All outputs are 0, including `mem_allowin`, which is forced 0 in the reset cycle and becomes 1 the cycle after reset deasserts.
- Reset mid-WAIT clears `discard_cnt`; the memory side is reset in the same cycle.
- Fields are stable while `mem_valid & ~wb_allowin`.

## Configuration
- `MEM_LOAD_FWD_EN` defined:
  - In WAIT, an attributed `data_ok` completes the stage the same cycle. `mem_ready_go`, `mem_wb_valid`, `mem_fwd_data` (extracted `data_sram_rdata`) and `mem_fwd_block=0` are all combinational from `data_ok`.
  - `rdata_q` is loaded only if `~wb_allowin`.
- Undefined: the response is always latched first. `mem_fwd_block` stays 1 through the `data_ok` cycle, and the load completes the cycle after.

## Test plan
- ALU op: `in_result=0x1234`, `in_req_sent=0`, `wb_allowin=1` -> `mem_wb_valid=1` the next cycle with `result=0x1234`; `mem_fwd_valid=1`.
- ld.b: `addr_low2=2'b11`, `rdata=0x80FF_0000`, `type=000` -> `result=0xFFFF_FF80`. Repeat with ld.bu (`type=100`) -> `0x0000_0080`.
- ld.h: `addr_low2=2'b10`, `rdata=0x8001_0000` -> `0xFFFF_8001`. `data_ok` delayed 3 cycles -> `mem_fwd_block=1` for those 3 cycles, `mem_allowin=0`.
- Flush in WAIT, new load captured, then two `data_ok` (`rdata` A, then B) -> A discarded, the new load gets B, and `discard_cnt` returns to 0.
- `wb_allowin=0` for 4 cycles after the load response -> `mem_wb_result` is held stable, with exactly one write-back transfer.
- `in_ex=1`, `in_req_sent=0` -> `mem_ex=1`, `mem_wb_ex=1`, `mem_fwd_valid=0`, and no `data_ok` wait.
